bouncing_square: RTL
====================

Name: bouncing_square

Overview:
- Pixel-generation stage that sits downstream of the vga timing generator, alongside color_square in the lab top; drives rgb.
- Draws one solid square that moves each frame and bounces off the screen edges.
- Keys control speed, pause and colour.
- Consumes hpos/vpos/display_on and produces a registered 3-bit rgb with 1 clock of latency.

Parameters:
- HPOS_WIDTH, 10, width of hpos.
- VPOS_WIDTH, 10, width of vpos.
- SCREEN_W, 640, visible pixels per line.
- SCREEN_H, 480, visible lines per frame.
- SIZE, 32, square side in pixels; must be less than SCREEN_H.
- SPEED_MAX, 4, maximum step in pixels per frame; range 1..15.

Ports:
- clk  input  1  system clock; same clock as the vga generator.
- reset_n  input  1  synchronous, active-low reset.
- display_on  input  1  high while hpos/vpos are in the visible area.
- hpos  input  HPOS_WIDTH  current pixel column.
- vpos  input  VPOS_WIDTH  current pixel line.
- key_sw  input  4  key levels, 1 = pressed, asynchronous to clk.
- rgb  output  3  pixel colour, registered.
- frame_tick  output  1  one-clock pulse at the start of vertical blanking.

Behaviour:
- Reset (reset_n low at a clk edge): all state loads on the next edge.
  - rgb=0, frame_tick=0.
  - x_pos=(SCREEN_W-SIZE)/2=304, y_pos=(SCREEN_H-SIZE)/2=224.
  - dir_x=+, dir_y=+, speed=1, colour=3'b010, FSM=RUN.
  - Key synchronisers and edge history clear to 0.
  - Reset mid-frame or mid-move takes effect immediately. There is no partial update.
- Frame tick:
  - Register vpos each clock as vpos_d.
  - frame_tick pulses for exactly 1 clock when vpos==SCREEN_H and vpos_d!=SCREEN_H.
  - The pulse is independent of how many clocks each pixel lasts (pixel-enable ratio).
- Keys:
  - Each bit passes through a 2-flop synchroniser, then rising-edge detection.
  - There is no debounce; bounce produces multiple events, which is accepted.
  - key[0] rise: speed+1, saturating at SPEED_MAX.
  - key[1] rise: speed-1, saturating at 1.
  - Both key[0] and key[1] rising in the same clock: speed unchanged.
  - key[2] rise: toggle FSM RUN<->PAUSED.
  - key[3] rise: colour+1; 3'b111 wraps to 3'b001, so colour is never 0.
  - Key events take effect on the clock after the edge is detected, independent of frame_tick.
- FSM:
  - RUN: positions update on the clock in which frame_tick is high.
  - PAUSED: positions and directions hold; rendering continues.
  - A key[2] edge in the same clock as frame_tick: the move uses the pre-toggle state.
- Motion on a frame_tick in RUN, x axis (limit LX=SCREEN_W-SIZE; y is identical with SCREEN_H and LY=SCREEN_H-SIZE):
  - dir +: if x_pos+speed >= LX then x_pos=LX and dir becomes -; else x_pos=x_pos+speed.
  - dir -: if x_pos <= speed then x_pos=0 and dir becomes +; else x_pos=x_pos-speed.
  - Compare with one extra bit of width (HPOS_WIDTH+1 / VPOS_WIDTH+1) so the sum never wraps.
  - The square never leaves [0,LX]x[0,LY].
  - The move uses the speed value registered before the tick clock.
- Rendering, registered, latency 1 clock:
  - inside = hpos>=x_pos && hpos<x_pos+SIZE && vpos>=y_pos && vpos<y_pos+SIZE, compared at extended width.
  - rgb <= !display_on ? 0 : inside ? colour : 3'b001 (blue background).
- Positions change only during vertical blanking, so no tearing occurs within a frame.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks with a running vga generator.
  - rgb=0, x_pos=304, y_pos=224, speed=1.
  - After release, pixel (304,224) reads 3'b010 one clock later; (303,224) reads 3'b001; blanking reads 0.
- Frame tick: run 3 frames.
  - Exactly 3 single-clock frame_tick pulses, each when vpos first equals 480.
  - The square moves +1,+1 per frame: (305,225), (306,226), (307,227).
- Right bounce: force x_pos=606, dir +, speed=4, then one tick.
  - x_pos=608 and dir becomes -.
  - Next tick: x_pos=604.
  - Top bounce: y_pos=2, dir -, speed=4 → y_pos=0, dir becomes +.
- Speed keys:
  - key[0] pulsed 6 times: speed=4, saturated.
  - key[1] pulsed 5 times: speed=1.
  - key[0] and key[1] rising in the same clock: speed unchanged.
- Pause and colour:
  - key[2] pulse, then 2 ticks: position unchanged.
  - key[2] again: motion resumes.
  - key[3] pulsed 6 times from 3'b010: colour 3'b001, the wrap from 3'b111 is verified.
- Reset mid-frame: assert reset_n=0 while vpos=100 and paused at (500,300).
  - Next clock: rgb=0, position (304,224), FSM=RUN.

Source files
------------

// File: rtl/bouncing_square.sv
// bouncing_square: pixel stage that draws one solid square, moves it once per
// frame and bounces it off the visible-area edges. Keys change the speed,
// pause/resume the motion and step the square colour. rgb and frame_tick
// are registered; rgb follows hpos/vpos/display_on with one clock of latency.
module bouncing_square #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SIZE       = 32,
    parameter int SPEED_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  display_on,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    input  logic [3:0]            key_sw,
    output logic [2:0]            rgb,
    output logic                  frame_tick
);

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSED = 1'b1} state_t;

    // Extended widths so position + speed / position + SIZE never wrap.
    localparam int HX = HPOS_WIDTH + 1;
    localparam int VX = VPOS_WIDTH + 1;

    localparam logic [HX-1:0]         LIM_X     = HX'(SCREEN_W - SIZE);
    localparam logic [VX-1:0]         LIM_Y     = VX'(SCREEN_H - SIZE);
    localparam logic [HX-1:0]         SIZE_X    = HX'(SIZE);
    localparam logic [VX-1:0]         SIZE_Y    = VX'(SIZE);
    localparam logic [HPOS_WIDTH-1:0] X_RST     = HPOS_WIDTH'((SCREEN_W - SIZE) / 2);
    localparam logic [VPOS_WIDTH-1:0] Y_RST     = VPOS_WIDTH'((SCREEN_H - SIZE) / 2);
    localparam logic [VPOS_WIDTH-1:0] VBLANK    = VPOS_WIDTH'(SCREEN_H);
    localparam logic [3:0]            SPEED_TOP = 4'(SPEED_MAX);

    // Key synchroniser and edge history.
    logic [3:0] key_meta_q, key_sync_q, key_prev_q;
    logic [3:0] key_rise_s;

    // Control, motion and output state.
    logic [VPOS_WIDTH-1:0] vpos_prev_q;
    logic                  frame_tick_q, frame_tick_d;
    state_t                state_q, state_d;
    logic [3:0]            speed_q, speed_d;
    logic [2:0]            colour_q, colour_d;
    logic [HPOS_WIDTH-1:0] x_pos_q, x_pos_d;
    logic [VPOS_WIDTH-1:0] y_pos_q, y_pos_d;
    logic                  dir_x_neg_q, dir_x_neg_d;
    logic                  dir_y_neg_q, dir_y_neg_d;
    logic [2:0]            rgb_q, rgb_d;

    logic [HX-1:0] x_ext_s, h_ext_s, spd_x_s;
    logic [VX-1:0] y_ext_s, v_ext_s, spd_y_s;
    logic          inside_s;

    assign key_rise_s = key_sync_q & ~key_prev_q;
    assign x_ext_s    = {1'b0, x_pos_q};
    assign y_ext_s    = {1'b0, y_pos_q};
    assign h_ext_s    = {1'b0, hpos};
    assign v_ext_s    = {1'b0, vpos};
    assign spd_x_s    = HX'(speed_q);
    assign spd_y_s    = VX'(speed_q);

    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

    // Two-flop synchroniser for the asynchronous keys plus one flop of edge history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_meta_q <= 4'd0;
            key_sync_q <= 4'd0;
            key_prev_q <= 4'd0;
        end else begin
            key_meta_q <= key_sw;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // Frame tick on the first clock of vblank; key-driven speed, colour and run/pause.
    always_comb begin
        frame_tick_d = (vpos == VBLANK) && (vpos_prev_q != VBLANK);
        speed_d      = speed_q;
        colour_d     = colour_q;
        state_d      = state_q;

        if (key_rise_s[0] && !key_rise_s[1]) begin
            if (speed_q < SPEED_TOP) begin
                speed_d = speed_q + 4'd1;
            end else begin
                speed_d = speed_q;
            end
        end else if (key_rise_s[1] && !key_rise_s[0]) begin
            if (speed_q > 4'd1) begin
                speed_d = speed_q - 4'd1;
            end else begin
                speed_d = speed_q;
            end
        end else begin
            speed_d = speed_q;
        end

        if (key_rise_s[3]) begin
            if (colour_q == 3'b111) begin
                colour_d = 3'b001;
            end else begin
                colour_d = colour_q + 3'd1;
            end
        end else begin
            colour_d = colour_q;
        end

        if (key_rise_s[2]) begin
            case (state_q)
                ST_RUN:    state_d = ST_PAUSED;
                ST_PAUSED: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Per-frame motion with clamp-and-reverse at each edge; uses pre-toggle state.
    always_comb begin
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;

        if (frame_tick_q && (state_q == ST_RUN)) begin
            if (!dir_x_neg_q) begin
                if ((x_ext_s + spd_x_s) >= LIM_X) begin
                    x_pos_d     = LIM_X[HPOS_WIDTH-1:0];
                    dir_x_neg_d = 1'b1;
                end else begin
                    x_pos_d = x_pos_q + HPOS_WIDTH'(speed_q);
                end
            end else begin
                if (x_ext_s <= spd_x_s) begin
                    x_pos_d     = {HPOS_WIDTH{1'b0}};
                    dir_x_neg_d = 1'b0;
                end else begin
                    x_pos_d = x_pos_q - HPOS_WIDTH'(speed_q);
                end
            end

            if (!dir_y_neg_q) begin
                if ((y_ext_s + spd_y_s) >= LIM_Y) begin
                    y_pos_d     = LIM_Y[VPOS_WIDTH-1:0];
                    dir_y_neg_d = 1'b1;
                end else begin
                    y_pos_d = y_pos_q + VPOS_WIDTH'(speed_q);
                end
            end else begin
                if (y_ext_s <= spd_y_s) begin
                    y_pos_d     = {VPOS_WIDTH{1'b0}};
                    dir_y_neg_d = 1'b0;
                end else begin
                    y_pos_d = y_pos_q - VPOS_WIDTH'(speed_q);
                end
            end
        end else begin
            x_pos_d     = x_pos_q;
            y_pos_d     = y_pos_q;
            dir_x_neg_d = dir_x_neg_q;
            dir_y_neg_d = dir_y_neg_q;
        end
    end

    // Pixel colour: black in blanking, square colour inside, blue background otherwise.
    always_comb begin
        inside_s = (h_ext_s >= x_ext_s) && (h_ext_s < (x_ext_s + SIZE_X)) &&
                   (v_ext_s >= y_ext_s) && (v_ext_s < (y_ext_s + SIZE_Y));
        if (!display_on) begin
            rgb_d = 3'b000;
        end else if (inside_s) begin
            rgb_d = colour_q;
        end else begin
            rgb_d = 3'b001;
        end
    end

    // State register; reset loads the centred square, speed 1, green, running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vpos_prev_q  <= {VPOS_WIDTH{1'b0}};
            frame_tick_q <= 1'b0;
            state_q      <= ST_RUN;
            speed_q      <= 4'd1;
            colour_q     <= 3'b010;
            x_pos_q      <= X_RST;
            y_pos_q      <= Y_RST;
            dir_x_neg_q  <= 1'b0;
            dir_y_neg_q  <= 1'b0;
            rgb_q        <= 3'b000;
        end else begin
            vpos_prev_q  <= vpos;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
            speed_q      <= speed_d;
            colour_q     <= colour_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            dir_x_neg_q  <= dir_x_neg_d;
            dir_y_neg_q  <= dir_y_neg_d;
            rgb_q        <= rgb_d;
        end
    end

endmodule
